// File: rtl/fir_xifu_mem_resp_if.sv
// XIF memory request/result channel and OBI data-memory port used by the FIR XIFU memory responder.

interface fir_xifu_mem_resp_xif_if #(
    parameter int unsigned X_ID_WIDTH = 4
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic [X_ID_WIDTH-1:0] mem_id;
    logic [31:0]           mem_addr;
    logic                  mem_we;
    logic [2:0]            mem_size;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_last;

    logic                  mem_result_valid;
    logic [X_ID_WIDTH-1:0] mem_result_id;
    logic [31:0]           mem_result_rdata;
    logic                  mem_result_err;

    modport master (
        output mem_valid, mem_id, mem_addr, mem_we, mem_size, mem_be, mem_wdata, mem_last,
        input  mem_ready, mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err
    );

    modport slave (
        input  mem_valid, mem_id, mem_addr, mem_we, mem_size, mem_be, mem_wdata, mem_last,
        output mem_ready, mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err
    );
endinterface

interface fir_xifu_mem_resp_obi_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/fir_xifu_mem_resp.sv
// Core-side XIF memory responder: forwards legal requests to OBI, answers illegal ones with an
// error, and returns single-beat results strictly in request order.

module fir_xifu_mem_resp #(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned DEPTH      = 2
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    fir_xifu_mem_resp_xif_if.slave     xif,
    fir_xifu_mem_resp_obi_if.master    obi
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [X_ID_WIDTH-1:0] pend_id_q [DEPTH];
    logic [X_ID_WIDTH-1:0] pend_id_d [DEPTH];
    logic                  pend_we_q [DEPTH];
    logic                  pend_we_d [DEPTH];

    logic                  res_valid_q, res_valid_d;
    logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;
    logic [31:0]           res_rdata_q, res_rdata_d;
    logic                  res_err_q, res_err_d;

    logic legal_c, full_c, empty_c, obi_req_c, push_c, pop_c, ill_acc_c;
    logic unused_last;

    assign unused_last = xif.mem_last;

    // Request decode and handshake; full/empty come from registered state only.
    always_comb begin
        legal_c = 1'b0;
        unique case (xif.mem_size)
            3'b001:  legal_c = 1'b1;
            3'b010:  legal_c = ~xif.mem_addr[0];
            3'b100:  legal_c = (xif.mem_addr[1:0] == 2'b00);
            default: legal_c = 1'b0;
        endcase
        full_c    = (count_q == CNT_W'(DEPTH));
        empty_c   = (count_q == '0);
        obi_req_c = xif.mem_valid & legal_c & ~full_c;
        push_c    = obi_req_c & obi.gnt;
        pop_c     = obi.rvalid & ~empty_c;
        // An illegal request may only complete once nothing older can still produce a result.
        ill_acc_c = xif.mem_valid & ~legal_c & empty_c & ~obi.rvalid;
    end

    assign xif.mem_ready = push_c | ill_acc_c;
    assign obi.req       = obi_req_c;
    assign obi.addr      = xif.mem_addr;
    assign obi.we        = xif.mem_we;
    assign obi.be        = xif.mem_be;
    assign obi.wdata     = xif.mem_wdata;

    assign xif.mem_result_valid = res_valid_q;
    assign xif.mem_result_id    = res_id_q;
    assign xif.mem_result_rdata = res_rdata_q;
    assign xif.mem_result_err   = res_err_q;

    // Pending-id FIFO and result next-state.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pend_id_d   = pend_id_q;
        pend_we_d   = pend_we_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_rdata_d = '0;
        res_err_d   = res_err_q;

        if (push_c) begin
            pend_id_d[wptr_q] = xif.mem_id;
            pend_we_d[wptr_q] = xif.mem_we;
            wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        end

        if (pop_c) begin
            rptr_d      = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            res_valid_d = 1'b1;
            res_id_d    = pend_id_q[rptr_q];
            res_err_d   = obi.err;
            res_rdata_d = (pend_we_q[rptr_q] | obi.err) ? 32'h0 : obi.rdata;
        end else if (ill_acc_c) begin
            res_valid_d = 1'b1;
            res_id_d    = xif.mem_id;
            res_err_d   = 1'b1;
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pend_id_q   <= '{default: '0};
            pend_we_q   <= '{default: 1'b0};
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rdata_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pend_id_q   <= pend_id_d;
            pend_we_q   <= pend_we_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_rdata_q <= res_rdata_d;
            res_err_q   <= res_err_d;
        end
    end

endmodule

// File: tb/tb_fir_xifu_mem_resp.sv
// Directed bench for fir_xifu_mem_resp: a behavioural OBI memory with fixed latency plus
// per-scenario tasks checking result content, ordering and cycle timing.

module tb_fir_xifu_mem_resp;

    localparam int unsigned XW = 4;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    fir_xifu_mem_resp_xif_if #(.X_ID_WIDTH(XW)) xif ();
    fir_xifu_mem_resp_obi_if obi ();

    fir_xifu_mem_resp #(.X_ID_WIDTH(XW), .DEPTH(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .xif    (xif),
        .obi    (obi)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    typedef struct {
        logic [XW-1:0] id;
        logic [31:0]   rdata;
        logic          err;
        int            cyc;
    } res_t;

    rsp_t mq[$];
    res_t obs[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    int n_req    = 0;
    int outstanding = 0;
    logic inject_err = 1'b0;

    logic [31:0] last_addr, last_wdata;
    logic        last_we;
    logic [3:0]  last_be;

    logic          pend_chk = 1'b0;
    logic [XW-1:0] s_id;
    logic [31:0]   s_addr, s_wdata;
    logic          s_we;
    logic [2:0]    s_size;
    logic [3:0]    s_be;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory response driver: one response per cycle, due lat cycles after acceptance.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rst_ni && mq.size() > 0 && mq[0].due == cyc) begin
            obi.rvalid = 1'b1;
            obi.rdata  = mq[0].rdata;
            obi.err    = mq[0].err;
            void'(mq.pop_front());
        end else begin
            obi.rvalid = 1'b0;
            obi.rdata  = 32'h0;
            obi.err    = 1'b0;
        end
    end

    // Mid-cycle monitor: OBI acceptance, result capture, protocol assertions.
    always @(negedge clk) begin
        if (!rst_ni) begin
            mq.delete();
            outstanding = 0;
            pend_chk    = 1'b0;
        end else begin
            if (obi.req) n_req = n_req + 1;
            if (obi.req && obi.gnt) begin
                mq.push_back('{rdata: (obi.we ? 32'hFFFF_FFFF : mem_rd(obi.addr)),
                               err: inject_err, due: cyc + lat});
                last_addr   = obi.addr;
                last_we     = obi.we;
                last_be     = obi.be;
                last_wdata  = obi.wdata;
                outstanding = outstanding + 1;
            end
            if (obi.rvalid) begin
                assert (outstanding > 0) else $error("obi rvalid with no pending request");
                outstanding = outstanding - 1;
            end
            if (xif.mem_result_valid)
                obs.push_back('{id: xif.mem_result_id, rdata: xif.mem_result_rdata,
                                err: xif.mem_result_err, cyc: cyc});
            if (pend_chk) begin
                assert (xif.mem_valid && xif.mem_id == s_id && xif.mem_addr == s_addr &&
                        xif.mem_we == s_we && xif.mem_size == s_size && xif.mem_be == s_be &&
                        xif.mem_wdata == s_wdata)
                    else $error("request dropped or changed before accept");
            end
            pend_chk = xif.mem_valid && !xif.mem_ready;
            s_id = xif.mem_id; s_addr = xif.mem_addr; s_we = xif.mem_we;
            s_size = xif.mem_size; s_be = xif.mem_be; s_wdata = xif.mem_wdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request (caller is just after a rising edge); acc returns the accept cycle.
    task automatic issue(input logic [XW-1:0] id, input logic [31:0] addr, input logic we,
                         input logic [2:0] size, input logic [3:0] be, input logic [31:0] wdata,
                         output int acc);
        bit done;
        done = 1'b0;
        acc  = -1;
        xif.mem_valid = 1'b1;
        xif.mem_id    = id;
        xif.mem_addr  = addr;
        xif.mem_we    = we;
        xif.mem_size  = size;
        xif.mem_be    = be;
        xif.mem_wdata = wdata;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (xif.mem_ready === 1'b1) begin
                done = 1'b1;
                acc  = cyc;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL accept_timeout id=%0d: no mem_ready within 50 cycles, required accept", id);
        end
        @(posedge clk);
        #1;
        xif.mem_valid = 1'b0;
    endtask

    // Wait for n captured results; pads with unknown entries on timeout so later checks fail.
    task automatic wait_res(input int n);
        for (int i = 0; i < 60 && obs.size() < n; i++) @(posedge clk);
        checks++;
        if (obs.size() < n) begin
            failures++;
            $display("FAIL result_timeout got=%0d results required=%0d", obs.size(), n);
            while (obs.size() < n) obs.push_back('{id: 'x, rdata: 'x, err: 1'bx, cyc: -1});
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks += 6;
        if (xif.mem_result_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", xif.mem_result_valid); end
        if (xif.mem_result_id !== 4'd0) begin failures++; $display("FAIL rst_id got=%0d exp=0", xif.mem_result_id); end
        if (xif.mem_result_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", xif.mem_result_rdata); end
        if (xif.mem_result_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", xif.mem_result_err); end
        if (xif.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", xif.mem_ready); end
        if (obi.req !== 1'b0) begin failures++; $display("FAIL rst_obi_req got=%b exp=0", obi.req); end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle(2);
    endtask

    task automatic test_single_load;
        int   acc;
        res_t r;
        obs.delete();
        lat = 1;
        issue(4'd3, 32'h100, 1'b0, 3'b100, 4'hF, 32'h0, acc);
        wait_res(1);
        r = obs.pop_front();
        checks += 4;
        if (r.id !== 4'd3) begin failures++; $display("FAIL load_id got=%0d exp=3", r.id); end
        if (r.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", r.rdata); end
        if (r.err !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", r.err); end
        if (r.cyc !== acc + 2) begin failures++; $display("FAIL load_latency got=%0d exp=%0d", r.cyc, acc + 2); end
        @(negedge clk);
        checks += 3;
        if (xif.mem_result_valid !== 1'b0) begin failures++; $display("FAIL load_pulse got=%b exp=0", xif.mem_result_valid); end
        if (xif.mem_result_rdata !== 32'h0) begin failures++; $display("FAIL load_rdata_zero got=%h exp=0", xif.mem_result_rdata); end
        if (xif.mem_result_id !== 4'd3) begin failures++; $display("FAIL load_id_hold got=%0d exp=3", xif.mem_result_id); end
        idle(2);
    endtask

    task automatic test_single_store;
        int   acc;
        res_t r;
        obs.delete();
        lat = 1;
        issue(4'd5, 32'h200, 1'b1, 3'b100, 4'b1111, 32'h1234_5678, acc);
        wait_res(1);
        r = obs.pop_front();
        checks += 7;
        if (last_addr !== 32'h200) begin failures++; $display("FAIL store_obi_addr got=%h exp=200", last_addr); end
        if (last_we !== 1'b1) begin failures++; $display("FAIL store_obi_we got=%b exp=1", last_we); end
        if (last_be !== 4'hF) begin failures++; $display("FAIL store_obi_be got=%h exp=f", last_be); end
        if (last_wdata !== 32'h1234_5678) begin failures++; $display("FAIL store_obi_wdata got=%h exp=12345678", last_wdata); end
        if (r.id !== 4'd5) begin failures++; $display("FAIL store_id got=%0d exp=5", r.id); end
        if (r.rdata !== 32'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", r.rdata); end
        if (r.err !== 1'b0) begin failures++; $display("FAIL store_err got=%b exp=0", r.err); end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int   a1, a2, a3;
        res_t r;
        logic [XW-1:0] exp_id [3];
        logic [31:0]   exp_rd [3];
        int            exp_cy [3];
        obs.delete();
        lat = 3;
        issue(4'd1, 32'h10, 1'b0, 3'b100, 4'hF, 32'h0, a1);
        issue(4'd2, 32'h14, 1'b0, 3'b100, 4'hF, 32'h0, a2);
        issue(4'd3, 32'h18, 1'b0, 3'b100, 4'hF, 32'h0, a3);
        wait_res(3);
        checks += 2;
        if (a2 !== a1 + 1) begin failures++; $display("FAIL b2b_accept2 got=%0d exp=%0d", a2, a1 + 1); end
        if (a3 !== a1 + 4) begin failures++; $display("FAIL b2b_full_stall got=%0d exp=%0d", a3, a1 + 4); end
        exp_id = '{4'd1, 4'd2, 4'd3};
        exp_rd = '{32'hA5A5_0010, 32'hA5A5_0014, 32'hA5A5_0018};
        exp_cy = '{a1 + 4, a1 + 5, a1 + 8};
        for (int k = 0; k < 3; k++) begin
            r = obs.pop_front();
            checks += 4;
            if (r.id !== exp_id[k]) begin failures++; $display("FAIL b2b_id[%0d] got=%0d exp=%0d", k, r.id, exp_id[k]); end
            if (r.rdata !== exp_rd[k]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", k, r.rdata, exp_rd[k]); end
            if (r.err !== 1'b0) begin failures++; $display("FAIL b2b_err[%0d] got=%b exp=0", k, r.err); end
            if (r.cyc !== exp_cy[k]) begin failures++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", k, r.cyc, exp_cy[k]); end
        end
        idle(2);
    endtask

    task automatic test_misaligned;
        int   acc, a8, a9, n0;
        res_t r;
        obs.delete();
        lat = 1;
        n0  = n_req;
        issue(4'd7, 32'h102, 1'b0, 3'b100, 4'hF, 32'h0, acc);
        wait_res(1);
        r = obs.pop_front();
        checks += 5;
        if (n_req !== n0) begin failures++; $display("FAIL mis_no_obi got=%0d req cycles exp=0", n_req - n0); end
        if (r.id !== 4'd7) begin failures++; $display("FAIL mis_id got=%0d exp=7", r.id); end
        if (r.err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", r.err); end
        if (r.rdata !== 32'h0) begin failures++; $display("FAIL mis_rdata got=%h exp=0", r.rdata); end
        if (r.cyc !== acc + 1) begin failures++; $display("FAIL mis_latency got=%0d exp=%0d", r.cyc, acc + 1); end
        idle(1);
        issue(4'd6, 32'h104, 1'b0, 3'b011, 4'hF, 32'h0, acc);
        wait_res(1);
        r = obs.pop_front();
        checks += 2;
        if (r.id !== 4'd6) begin failures++; $display("FAIL badsize_id got=%0d exp=6", r.id); end
        if (r.err !== 1'b1) begin failures++; $display("FAIL badsize_err got=%b exp=1", r.err); end
        idle(1);
        lat = 3;
        issue(4'd8, 32'h20, 1'b0, 3'b100, 4'hF, 32'h0, a8);
        issue(4'd9, 32'h201, 1'b0, 3'b010, 4'h3, 32'h0, a9);
        wait_res(2);
        checks += 1;
        if (a9 !== a8 + 4) begin failures++; $display("FAIL mis_wait_accept got=%0d exp=%0d", a9, a8 + 4); end
        r = obs.pop_front();
        checks += 3;
        if (r.id !== 4'd8) begin failures++; $display("FAIL order_first_id got=%0d exp=8", r.id); end
        if (r.rdata !== 32'hA5A5_0020) begin failures++; $display("FAIL order_first_rdata got=%h exp=a5a50020", r.rdata); end
        if (r.cyc !== a8 + 4) begin failures++; $display("FAIL order_first_cycle got=%0d exp=%0d", r.cyc, a8 + 4); end
        r = obs.pop_front();
        checks += 3;
        if (r.id !== 4'd9) begin failures++; $display("FAIL order_second_id got=%0d exp=9", r.id); end
        if (r.err !== 1'b1) begin failures++; $display("FAIL order_second_err got=%b exp=1", r.err); end
        if (r.cyc !== a8 + 5) begin failures++; $display("FAIL order_second_cycle got=%0d exp=%0d", r.cyc, a8 + 5); end
        idle(2);
    endtask

    task automatic test_bus_error;
        int   acc;
        res_t r;
        obs.delete();
        lat = 1;
        inject_err = 1'b1;
        issue(4'd4, 32'h300, 1'b0, 3'b100, 4'hF, 32'h0, acc);
        inject_err = 1'b0;
        wait_res(1);
        r = obs.pop_front();
        checks += 3;
        if (r.id !== 4'd4) begin failures++; $display("FAIL buserr_id got=%0d exp=4", r.id); end
        if (r.err !== 1'b1) begin failures++; $display("FAIL buserr_err got=%b exp=1", r.err); end
        if (r.rdata !== 32'h0) begin failures++; $display("FAIL buserr_rdata got=%h exp=0", r.rdata); end
        idle(2);
    endtask

    task automatic test_reset_mid;
        int   a, acc;
        res_t r;
        obs.delete();
        lat = 5;
        issue(4'd10, 32'h40, 1'b0, 3'b100, 4'hF, 32'h0, a);
        issue(4'd11, 32'h44, 1'b0, 3'b100, 4'hF, 32'h0, a);
        rst_ni = 1'b0;
        @(negedge clk);
        checks += 5;
        if (xif.mem_result_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", xif.mem_result_valid); end
        if (xif.mem_result_id !== 4'd0) begin failures++; $display("FAIL midrst_id got=%0d exp=0", xif.mem_result_id); end
        if (xif.mem_result_err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", xif.mem_result_err); end
        if (xif.mem_result_rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata got=%h exp=0", xif.mem_result_rdata); end
        if (obi.req !== 1'b0) begin failures++; $display("FAIL midrst_obi_req got=%b exp=0", obi.req); end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle(1);
        obs.delete();
        lat = 1;
        issue(4'd0, 32'h100, 1'b0, 3'b100, 4'hF, 32'h0, acc);
        wait_res(1);
        r = obs.pop_front();
        idle(8);
        checks += 5;
        if (r.id !== 4'd0) begin failures++; $display("FAIL postrst_id got=%0d exp=0", r.id); end
        if (r.rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL postrst_rdata got=%h exp=deadbeef", r.rdata); end
        if (r.err !== 1'b0) begin failures++; $display("FAIL postrst_err got=%b exp=0", r.err); end
        if (r.cyc !== acc + 2) begin failures++; $display("FAIL postrst_latency got=%0d exp=%0d", r.cyc, acc + 2); end
        if (obs.size() !== 0) begin failures++; $display("FAIL postrst_stale got=%0d extra results exp=0", obs.size()); end
    endtask

    initial begin
        xif.mem_valid = 1'b0;
        xif.mem_id    = '0;
        xif.mem_addr  = 32'h0;
        xif.mem_we    = 1'b0;
        xif.mem_size  = 3'b000;
        xif.mem_be    = 4'h0;
        xif.mem_wdata = 32'h0;
        xif.mem_last  = 1'b1;
        obi.gnt       = 1'b1;
        obi.rvalid    = 1'b0;
        obi.rdata     = 32'h0;
        obi.err       = 1'b0;

        test_reset();
        test_single_load();
        test_single_store();
        test_back_to_back();
        test_misaligned();
        test_bus_error();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
